// File: rtl/bcd2binary_seq_pkg.sv
// Shared constants, state encoding and digit helper for the BCD-to-binary converter.
package bcd2binary_seq_pkg;

   localparam int WORDSIZE_DEF = 8;   // default result width (1..20)
   localparam int BCD_DIGITS   = 6;   // decimal digits accepted
   localparam int BIN_ITER     = 20;  // shift iterations; 999999 fits in 20 bits

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // True when any nibble of the packed digit word is not a decimal digit.
   function automatic logic any_bad_digit(input logic [BCD_DIGITS*4-1:0] d);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < BCD_DIGITS; k++) begin
         if (d[k*4 +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/bcd2binary_seq_sub3.sv
// Per-nibble correction for reverse double-dabble: values of 8 or more drop by 3.
module bcd2binary_seq_sub3 (
   input  logic [3:0] i_x,
   output logic [3:0] o_y
);

   assign o_y = (i_x >= 4'd8) ? (i_x - 4'd3) : i_x;

endmodule

// File: rtl/bcd2binary_seq.sv
// Six-digit BCD to binary converter using iterative reverse double-dabble.
// A valid request takes 20 shift cycles; a request with a non-decimal digit
// reports err on the very next cycle without converting.
module bcd2binary_seq
   import bcd2binary_seq_pkg::*;
#(
   parameter int WORDSIZE = WORDSIZE_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [3:0]          in5,
   input  logic [3:0]          in4,
   input  logic [3:0]          in3,
   input  logic [3:0]          in2,
   input  logic [3:0]          in1,
   input  logic [3:0]          in0,
   output logic                busy,
   output logic                done,
   output logic [WORDSIZE-1:0] out,
   output logic                overflow,
   output logic                err
);

   localparam int          SR_W      = BCD_DIGITS*4 + BIN_ITER;
   localparam logic [4:0]  LAST_ITER = 5'(BIN_ITER - 1);

   state_t                  r_state;
   logic [SR_W-1:0]         r_sr;
   logic [4:0]              r_cnt;
   logic                    r_busy;
   logic                    r_done;
   logic [WORDSIZE-1:0]     r_out;
   logic                    r_ovf;
   logic                    r_err;

   logic [BCD_DIGITS*4-1:0] w_digits;
   logic                    w_bad;
   logic [SR_W-1:0]         w_shift;
   logic [BCD_DIGITS*4-1:0] w_corr;
   logic [SR_W-1:0]         w_next;
   logic                    w_ovf;

   assign w_digits = {in5, in4, in3, in2, in1, in0};
   assign w_bad    = any_bad_digit(w_digits);

   // One iteration: shift right, then correct every BCD nibble.
   assign w_shift = r_sr >> 1;

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_nib
      bcd2binary_seq_sub3 u_sub3 (
         .i_x (w_shift[BIN_ITER + 4*g +: 4]),
         .o_y (w_corr[4*g +: 4])
      );
   end

   assign w_next = {w_corr, w_shift[BIN_ITER-1:0]};

   // Bits of the 20-bit result that do not fit in the output word.
   if (WORDSIZE < BIN_ITER) begin : g_ovf
      assign w_ovf = |w_next[BIN_ITER-1:WORDSIZE];
   end else begin : g_noovf
      assign w_ovf = 1'b0;
   end

   // Control FSM with datapath; results are only written on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_out   <= '0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_bad) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_out   <= '0;
                     r_ovf   <= 1'b0;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_SHIFT;
                     r_sr    <= {w_digits, {BIN_ITER{1'b0}}};
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               r_sr  <= w_next;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == LAST_ITER) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_out   <= w_next[WORDSIZE-1:0];
                  r_ovf   <= w_ovf;
                  r_err   <= 1'b0;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign out      = r_out;
   assign overflow = r_ovf;
   assign err      = r_err;

endmodule
